// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the async FIFO.
// The arbiter connects through the slave modport. The master modport is the
// producer/FIFO view.
// The optional stall_cnt signal exists only when FIFO_ARB_STALL_CNT_EN is defined.
interface fifo_write_arbiter_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic                          full;
    logic                          w_en;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]                   stall_cnt;

    modport master (output req, req_data, full,
                    input  w_en, data_in, gnt, busy, stall_cnt);
    modport slave  (input  req, req_data, full,
                    output w_en, data_in, gnt, busy, stall_cnt);
`else
    modport master (output req, req_data, full,
                    input  w_en, data_in, gnt, busy);
    modport slave  (input  req, req_data, full,
                    output w_en, data_in, gnt, busy);
`endif
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the async FIFO write port (wclk domain only).
// Flow: IDLE -> ARB (register winner) -> GRANT (one write per cycle).
// While a write is in progress, the next winner is chosen one cycle ahead. This
// gives sustained one-write-per-cycle throughput.
// Optional: define FIFO_ARB_STALL_CNT_EN to add a saturating stall_cnt output.
// That counter counts GRANT cycles that are blocked by full.
module fifo_write_arbiter #(
    parameter  int FIFO_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_write_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t                               state, state_nxt;
    logic [IDX_W-1:0]                     winner, winner_nxt;
    logic [IDX_W-1:0]                     last, last_nxt;
    logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]   data_arr;
    logic [IDX_W:0]                       arb_pick, la_pick;
    logic                                 wr;

    // Pick the first set request after 'base', wrapping modulo NUM_REQ.
    // The result is {found, index}. When excl_base is set, base itself is
    // skipped: a requester that was just served goes behind all the others.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   base,
                                               input logic               excl_base);
        logic [NUM_REQ-1:0] rot;
        int                 s;
        // rot[k] holds request (base+1+k) mod NUM_REQ.
        rot = NUM_REQ'(({r, r} >> base) >> 1);
        if (excl_base) rot[NUM_REQ-1] = 1'b0;
        rr_pick = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                s       = (int'(base) + 1 + k) % NUM_REQ;
                rr_pick = {1'b1, IDX_W'(s)};
            end
        end
    endfunction

    assign data_arr = bus.req_data;
    assign arb_pick = rr_pick(bus.req, last, 1'b0);
    assign la_pick  = rr_pick(bus.req, winner, 1'b1);

    // Write only while the winner still requests and the FIFO has room.
    assign wr          = (state == GRANT) && bus.req[winner] && !bus.full;
    assign bus.w_en    = wr;
    assign bus.gnt     = wr ? (NUM_REQ'(1) << winner) : '0;
    assign bus.data_in = (state == GRANT) ? data_arr[winner] : '0;
    assign bus.busy    = (state != IDLE);

    // State, winner and last-served registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            winner <= '0;
            last   <= IDX_W'(NUM_REQ-1);
        end else begin
            state  <= state_nxt;
            winner <= winner_nxt;
            last   <= last_nxt;
        end
    end

    // Next-state logic: arbitrate, stream grants with look-ahead, stall on full,
    // and abandon the grant if the winner withdraws.
    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        last_nxt   = last;
        case (state)
            IDLE: if (|bus.req) state_nxt = ARB;
            ARB: begin
                if (arb_pick[IDX_W]) begin
                    winner_nxt = arb_pick[IDX_W-1:0];
                    state_nxt  = GRANT;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            GRANT: begin
                if (!bus.req[winner]) begin
                    state_nxt = ARB;            // dropped before gnt; last untouched
                end else if (!bus.full) begin
                    last_nxt = winner;
                    if (la_pick[IDX_W]) winner_nxt = la_pick[IDX_W-1:0];
                    else                state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where the winner is ready but the FIFO is full.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            stall_cnt_q <= '0;
        else if ((state == GRANT) && bus.full && bus.req[winner] && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter.
// It uses NUM_REQ=4 as the main instance, plus NUM_REQ=3 and 5 instances for
// the wrap checks.
// Inputs change 2 time units after posedge. Outputs are checked 1 time unit
// after that.
module tb_fifo_write_arbiter;
    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    int   checks = 0;
    int   errs   = 0;

    always #5 wclk = ~wclk;

    fifo_write_arbiter_if #(.FIFO_WIDTH(32), .NUM_REQ(4)) bus4 ();
    fifo_write_arbiter_if #(.FIFO_WIDTH(32), .NUM_REQ(3)) bus3 ();
    fifo_write_arbiter_if #(.FIFO_WIDTH(32), .NUM_REQ(5)) bus5 ();

    fifo_write_arbiter #(.FIFO_WIDTH(32), .NUM_REQ(4)) dut4 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus4));
    fifo_write_arbiter #(.FIFO_WIDTH(32), .NUM_REQ(3)) dut3 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus3));
    fifo_write_arbiter #(.FIFO_WIDTH(32), .NUM_REQ(5)) dut5 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus5));

    task automatic tick;
        @(posedge wclk);
        #2;
    endtask

    task automatic test_reset;
        bus4.req = '0; bus4.full = 1'b0;
        bus3.req = '0; bus3.full = 1'b0;
        bus5.req = '0; bus5.full = 1'b0;
        for (int i = 0; i < 4; i++) bus4.req_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        for (int i = 0; i < 3; i++) bus3.req_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        for (int i = 0; i < 5; i++) bus5.req_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        wrst_n = 1'b0;
        tick;
        #1;
        checks++; if (bus4.w_en !== 1'b0)      begin errs++; $display("FAIL reset_w_en: got %b exp 0", bus4.w_en); end
        checks++; if (bus4.gnt !== 4'b0000)    begin errs++; $display("FAIL reset_gnt: got %b exp 0000", bus4.gnt); end
        checks++; if (bus4.data_in !== 32'h0)  begin errs++; $display("FAIL reset_data_in: got %h exp 0", bus4.data_in); end
        checks++; if (bus4.busy !== 1'b0)      begin errs++; $display("FAIL reset_busy: got %b exp 0", bus4.busy); end
`ifdef FIFO_ARB_STALL_CNT_EN
        checks++; if (bus4.stall_cnt !== 16'h0) begin errs++; $display("FAIL reset_stall_cnt: got %0d exp 0", bus4.stall_cnt); end
`endif
        wrst_n = 1'b1;
        tick;
        #1;
        checks++; if (bus4.busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b exp 0", bus4.busy); end
    endtask

    // Starts from reset (last=3), so the order must begin at 0.
    task automatic test_fairness;
        logic [3:0] exp;
        bus4.req = 4'hF;
        tick;
        #1;
        checks++; if (bus4.busy !== 1'b1 || bus4.w_en !== 1'b0) begin errs++; $display("FAIL fair_arb: busy=%b w_en=%b exp busy=1 w_en=0", bus4.busy, bus4.w_en); end
        tick;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp = 4'b0001 << (k % 4);
            checks++; if (bus4.gnt !== exp) begin errs++; $display("FAIL fair_gnt[%0d]: got %b exp %b", k, bus4.gnt, exp); end
            checks++; if (bus4.data_in !== (32'hA5A5_0000 | 32'(k % 4))) begin errs++; $display("FAIL fair_data[%0d]: got %h exp %h", k, bus4.data_in, 32'hA5A5_0000 | 32'(k % 4)); end
            checks++; if (bus4.w_en !== |bus4.gnt || bus4.w_en !== 1'b1) begin errs++; $display("FAIL fair_w_en[%0d]: got %b exp 1", k, bus4.w_en); end
            tick;
        end
        bus4.req = 4'h0;
        tick;
        tick;
        #1;
        checks++; if (bus4.busy !== 1'b0) begin errs++; $display("FAIL fair_idle: got busy=%b exp 0", bus4.busy); end
    endtask

    // last=3: req2 alone is granted on the second edge.
    task automatic test_single;
        bus4.req = 4'b0100;
        tick;
        #1;
        checks++; if (bus4.w_en !== 1'b0 || bus4.gnt !== 4'b0000) begin errs++; $display("FAIL single_early: w_en=%b gnt=%b exp 0/0000", bus4.w_en, bus4.gnt); end
        tick;
        #1;
        checks++; if (bus4.gnt !== 4'b0100)        begin errs++; $display("FAIL single_gnt: got %b exp 0100", bus4.gnt); end
        checks++; if (bus4.w_en !== 1'b1)          begin errs++; $display("FAIL single_w_en: got %b exp 1", bus4.w_en); end
        checks++; if (bus4.data_in !== 32'hA5A5_0002) begin errs++; $display("FAIL single_data: got %h exp a5a50002", bus4.data_in); end
        tick;
        bus4.req = 4'b0000;
        #1;
        checks++; if (bus4.w_en !== 1'b0 || bus4.busy !== 1'b0) begin errs++; $display("FAIL single_after: w_en=%b busy=%b exp 0/0", bus4.w_en, bus4.busy); end
    endtask

    // last=2: req1 wins, then full holds it off for 5 cycles.
    task automatic test_full_stall;
        bus4.req  = 4'b0010;
        bus4.full = 1'b1;
        tick;
        tick;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus4.w_en !== 1'b0 || bus4.gnt !== 4'b0000 || bus4.busy !== 1'b1) begin errs++; $display("FAIL stall[%0d]: w_en=%b gnt=%b busy=%b exp 0/0000/1", c, bus4.w_en, bus4.gnt, bus4.busy); end
            tick;
        end
        bus4.full = 1'b0;
        #1;
        checks++; if (bus4.gnt !== 4'b0010 || bus4.w_en !== 1'b1) begin errs++; $display("FAIL stall_release: gnt=%b w_en=%b exp 0010/1", bus4.gnt, bus4.w_en); end
        checks++; if (bus4.data_in !== 32'hA5A5_0001) begin errs++; $display("FAIL stall_data: got %h exp a5a50001", bus4.data_in); end
`ifdef FIFO_ARB_STALL_CNT_EN
        checks++; if (bus4.stall_cnt !== 16'd5) begin errs++; $display("FAIL stall_cnt: got %0d exp 5", bus4.stall_cnt); end
`endif
        tick;
        bus4.req = 4'b0000;
        #1;
        checks++; if (bus4.busy !== 1'b0) begin errs++; $display("FAIL stall_idle: got busy=%b exp 0", bus4.busy); end
    endtask

    // last=1: req3 wins under full and then withdraws. With last still 1,
    // req2 must beat req0 on the re-arbitration.
    task automatic test_abandon;
        bus4.req  = 4'b1000;
        bus4.full = 1'b1;
        tick;
        tick;
        #1;
        checks++; if (bus4.w_en !== 1'b0 || bus4.gnt !== 4'b0000) begin errs++; $display("FAIL abandon_full: w_en=%b gnt=%b exp 0/0000", bus4.w_en, bus4.gnt); end
        bus4.req  = 4'b0101;
        bus4.full = 1'b0;
        #1;
        checks++; if (bus4.w_en !== 1'b0 || bus4.gnt !== 4'b0000) begin errs++; $display("FAIL abandon_drop: w_en=%b gnt=%b exp 0/0000", bus4.w_en, bus4.gnt); end
        tick;
        #1;
        checks++; if (bus4.busy !== 1'b1 || bus4.w_en !== 1'b0) begin errs++; $display("FAIL abandon_arb: busy=%b w_en=%b exp 1/0", bus4.busy, bus4.w_en); end
        tick;
        #1;
        checks++; if (bus4.gnt !== 4'b0100) begin errs++; $display("FAIL abandon_next: got %b exp 0100", bus4.gnt); end
        checks++; if (bus4.data_in !== 32'hA5A5_0002) begin errs++; $display("FAIL abandon_data: got %h exp a5a50002", bus4.data_in); end
        tick;
        bus4.req = 4'b0001;
        #1;
        checks++; if (bus4.gnt !== 4'b0001) begin errs++; $display("FAIL abandon_follow: got %b exp 0001", bus4.gnt); end
        tick;
        bus4.req = 4'b0000;
        #1;
        checks++; if (bus4.busy !== 1'b0) begin errs++; $display("FAIL abandon_idle: got busy=%b exp 0", bus4.busy); end
    endtask

    // Reset while writing. After reset, last=3, so req0 goes before req3.
    task automatic test_reset_mid_op;
        bus4.req = 4'b0010;
        tick;
        tick;
        #1;
        checks++; if (bus4.w_en !== 1'b1) begin errs++; $display("FAIL rst_pre_w_en: got %b exp 1", bus4.w_en); end
        wrst_n = 1'b0;
        #1;
        checks++; if (bus4.w_en !== 1'b0 || bus4.gnt !== 4'b0000 || bus4.busy !== 1'b0) begin errs++; $display("FAIL rst_mid: w_en=%b gnt=%b busy=%b exp 0/0000/0", bus4.w_en, bus4.gnt, bus4.busy); end
        checks++; if (bus4.data_in !== 32'h0) begin errs++; $display("FAIL rst_mid_data: got %h exp 0", bus4.data_in); end
        tick;
        wrst_n   = 1'b1;
        bus4.req = 4'b1001;
        tick;
        tick;
        #1;
        checks++; if (bus4.gnt !== 4'b0001) begin errs++; $display("FAIL wrap4_first: got %b exp 0001", bus4.gnt); end
        tick;
        #1;
        checks++; if (bus4.gnt !== 4'b1000) begin errs++; $display("FAIL wrap4_second: got %b exp 1000", bus4.gnt); end
        checks++; if (bus4.data_in !== 32'hA5A5_0003) begin errs++; $display("FAIL wrap4_data: got %h exp a5a50003", bus4.data_in); end
        tick;
        bus4.req = 4'b0000;
        tick;
        tick;
    endtask

    // Rotation for odd NUM_REQ values. Both instances start from last=N-1.
    task automatic test_wrap;
        logic [2:0] exp3;
        logic [4:0] exp5;
        int         seq5 [3] = '{0, 1, 4};
        bus3.req = 3'b111;
        bus5.req = 5'b10011;
        tick;
        tick;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp3 = 3'b001 << (k % 3);
            exp5 = 5'b00001 << seq5[k % 3];
            checks++; if (bus3.gnt !== exp3) begin errs++; $display("FAIL wrap3_gnt[%0d]: got %b exp %b", k, bus3.gnt, exp3); end
            checks++; if (bus5.gnt !== exp5) begin errs++; $display("FAIL wrap5_gnt[%0d]: got %b exp %b", k, bus5.gnt, exp5); end
            checks++; if (bus5.data_in !== (32'hA5A5_0000 | 32'(seq5[k % 3]))) begin errs++; $display("FAIL wrap5_data[%0d]: got %h exp %h", k, bus5.data_in, 32'hA5A5_0000 | 32'(seq5[k % 3])); end
            tick;
        end
        bus3.req = '0;
        bus5.req = '0;
        tick;
        tick;
        #1;
        checks++; if (bus3.busy !== 1'b0 || bus5.busy !== 1'b0) begin errs++; $display("FAIL wrap_idle: busy3=%b busy5=%b exp 0/0", bus3.busy, bus5.busy); end
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_single;
        test_full_stall;
        test_abandon;
        test_reset_mid_op;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
